fifo_fwft_stat: RTL and testbench

- Parametrised successor to the team's basic synchronous FIFO.
- Keeps first-word-fall-through read semantics: the head word is visible on o_data whenever the FIFO is not empty, and rden pops it.
- Adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with a clear input.
- Sits between producer and consumer logic in the same clock domain, e.g. buffering between modules in the minilab datapaths.

---
 rtl/fifo_fwft_stat.sv | 110 +++++++++++
 tb/tb_fifo_fwft_stat.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_stat.sv
// First-word-fall-through synchronous FIFO with any depth >= 2, occupancy count,
// almost-full/almost-empty thresholds and sticky error flags. Define FIFO_FLUSH_EN to add a flush input.
module fifo_fwft_stat #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  err_clr,
`ifdef FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  do_wr_s;
    logic                  do_rd_s;
    logic                  flush_s;

    // Explicit compare keeps the wrap correct for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? {PW{1'b0}} : p + PW'(1);
    endfunction

`ifdef FIFO_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign full         = (count_r == CW'(DEPTH));
    assign empty        = (count_r == {CW{1'b0}});
    assign almost_full  = (count_r >= CW'(AF_THRESH));
    assign almost_empty = (count_r <= CW'(AE_THRESH));
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    // A pop while full frees the slot the simultaneous push lands in.
    assign do_wr_s = wren & (~full | rden);
    assign do_rd_s = rden & ~empty;

    assign o_data = empty ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_wr_s && !flush_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_rd_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; a new event outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= (wren & full & ~rden) | (overflow_r & ~err_clr);
            underflow_r <= (rden & empty) | (underflow_r & ~err_clr);
        end
    end

endmodule

// File: tb/tb_fifo_fwft_stat.sv
// Directed self-checking bench for fifo_fwft_stat (DEPTH=6, AF=5, AE=1).
// Exercises the flush input as well when FIFO_FLUSH_EN is defined.
module tb_fifo_fwft_stat;

    localparam int DEPTH = 6;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wren;
    logic          rden;
    logic [DW-1:0] i_data;
    logic          err_clr;
`ifdef FIFO_FLUSH_EN
    logic          flush;
`endif
    logic [DW-1:0] o_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int n_pass  = 0;
    int n_total = 0;

    fifo_fwft_stat #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(5), .AE_THRESH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wren(wren), .rden(rden), .i_data(i_data),
        .err_clr(err_clr),
`ifdef FIFO_FLUSH_EN
        .flush(flush),
`endif
        .o_data(o_data), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wren = 1'b1; i_data = d;
        tick();
        wren = 1'b0;
    endtask

    task automatic pop();
        rden = 1'b1;
        tick();
        rden = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wren = 1'b0; rden = 1'b0; i_data = 8'h00; err_clr = 1'b0;
`ifdef FIFO_FLUSH_EN
        flush = 1'b0;
`endif
        // 1. reset state
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_odata", 32'(o_data), 32'h00);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);

        // 2. single word fall-through
        push(8'hAA);
        chk("t2_odata", 32'(o_data), 32'hAA);
        chk("t2_count", 32'(count), 32'd1);
        chk("t2_empty", 32'(empty), 32'd0);
        chk("t2_ae", 32'(almost_empty), 32'd1);
        pop();
        chk("t2_empty_after", 32'(empty), 32'd1);
        chk("t2_odata_after", 32'(o_data), 32'h00);

        // 3. fill, overflow, drain
        for (int i = 1; i <= 6; i++) begin
            push(DW'(i));
            chk($sformatf("t3_count%0d", i), 32'(count), 32'(i));
            chk($sformatf("t3_af%0d", i), 32'(almost_full), (i >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("t3_full%0d", i), 32'(full), (i == 6) ? 32'd1 : 32'd0);
            chk($sformatf("t3_ae%0d", i), 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
        end
        push(8'hFF);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_count_ovf", 32'(count), 32'd6);
        chk("t3_udf_clean", 32'(underflow), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("t3_rd%0d", i), 32'(o_data), 32'(i));
            pop();
        end
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_count0", 32'(count), 32'd0);

        // 4. pointer wrap over three rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) push(DW'(8'h10 + r * 4 + i));
            chk($sformatf("t4_count_r%0d", r), 32'(count), 32'd4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t4_r%0d_w%0d", r, i), 32'(o_data), 32'(8'h10 + r * 4 + i));
                pop();
            end
            chk($sformatf("t4_empty_r%0d", r), 32'(empty), 32'd1);
        end

        // clear overflow left from test 3
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);

        // 5a. simultaneous write/read while full
        for (int i = 0; i < 6; i++) push(DW'(8'h20 + i));
        chk("t5_full", 32'(full), 32'd1);
        wren = 1'b1; rden = 1'b1; i_data = 8'h77;
        tick();
        wren = 1'b0; rden = 1'b0;
        chk("t5_count", 32'(count), 32'd6);
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_head", 32'(o_data), 32'h21);
        for (int i = 1; i < 6; i++) begin
            chk($sformatf("t5_rd%0d", i), 32'(o_data), 32'(8'h20 + i));
            pop();
        end
        chk("t5_last", 32'(o_data), 32'h77);
        pop();
        chk("t5_empty", 32'(empty), 32'd1);

        // 5b. simultaneous write/read while empty
        wren = 1'b1; rden = 1'b1; i_data = 8'h55;
        tick();
        wren = 1'b0; rden = 1'b0;
        chk("t5_udf", 32'(underflow), 32'd1);
        chk("t5_count1", 32'(count), 32'd1);
        chk("t5_odata55", 32'(o_data), 32'h55);
        pop();

        // 6. error clear, set-wins on coincidence, underflow leaves state alone
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t6_ovf_clr", 32'(overflow), 32'd0);
        chk("t6_udf_clr", 32'(underflow), 32'd0);
        err_clr = 1'b1; rden = 1'b1; tick(); err_clr = 1'b0; rden = 1'b0;
        chk("t6_set_wins", 32'(underflow), 32'd1);
        chk("t6_count_udf", 32'(count), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t6_udf_clr2", 32'(underflow), 32'd0);

`ifdef FIFO_FLUSH_EN
        for (int i = 0; i < 3; i++) push(DW'(8'h30 + i));
        chk("t6_pre_flush", 32'(count), 32'd3);
        flush = 1'b1; wren = 1'b1; i_data = 8'h99;
        tick();
        flush = 1'b0; wren = 1'b0;
        chk("t6_flush_count", 32'(count), 32'd0);
        chk("t6_flush_empty", 32'(empty), 32'd1);
        chk("t6_flush_odata", 32'(o_data), 32'h00);
`endif

        // asynchronous reset mid-operation
        push(8'h41); push(8'h42);
        chk("rst_mid_pre", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_empty", 32'(empty), 32'd1);
        chk("rst_mid_odata", 32'(o_data), 32'h00);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
